// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared types and default timing for the four-approach phase scheduler.
//   state_e       : scheduler phase, also exported on the debug 'phase' port
//   NUM_APPROACH  : number of approaches / crossings (fixed at 4)
//   DEF_*         : default interval lengths in clock cycles
//   max_of()      : constant helper used to size the phase timer
// ---------------------------------------------------------------------------
package traffic_pkg;

  localparam int NUM_APPROACH = 4;

  localparam int DEF_MIN_GREEN = 4;
  localparam int DEF_MAX_GREEN = 12;
  localparam int DEF_AMBER_T   = 2;
  localparam int DEF_ALLRED_T  = 1;
  localparam int DEF_WALK_T    = 4;
  localparam int DEF_STARVE_T  = 24;

  typedef enum logic [2:0] {
    ALL_RED  = 3'd0,
    GREEN    = 3'd1,
    AMBER    = 3'd2,
    PED_WALK = 3'd3
  } state_e;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
// Combinational round-robin pick over four requests. The search starts at
// i_ptr and walks upward modulo 4; the first set request wins.
//   i_req   [3:0] : pending requests
//   i_ptr   [1:0] : highest-priority index for this pick
//   o_grant [3:0] : one-hot winner, zero when nothing is requested
//   o_valid       : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter4
  import traffic_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_grant,
  output logic       o_valid
);

  logic [1:0] w_idx;
  logic       w_found;

  // NOTE: every signal written here gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_APPROACH; k++) begin
      w_idx = i_ptr + 2'(k);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler
// Grants green to at most one of four approaches using round-robin over
// latched vehicle requests, gives pedestrian walk priority at each all-red
// decision point, and sequences amber / all-red / walk intervals. Every lamp
// output is a register loaded from the next-state decode, so lamps change on
// the same edge as the state.
//
// Ports:
//   clock          : system clock, rising edge
//   reset          : asynchronous, active-low reset
//   veh_req  [3:0] : vehicle sensors (level), bit i = approach i
//   ped_req  [3:0] : pedestrian buttons (level), bit i = crossing i
//   red/amber/green [3:0] : vehicle lamps; green is one-hot or zero
//   ped_green/ped_red [3:0] : walk / don't-walk lamps (ped_red = ~ped_green)
//   alarm    [3:0] : per-approach starvation alarm
//   phase    [2:0] : current state_e encoding, for debug
//
// Build option: define TRAFFIC_STARVE_ALARM_EN to build per-approach wait
// counters driving 'alarm'; otherwise 'alarm' is tied to zero.
// ---------------------------------------------------------------------------
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int AMBER_T   = DEF_AMBER_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int WALK_T    = DEF_WALK_T,
  parameter int STARVE_T  = DEF_STARVE_T
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] veh_req,
  input  logic [3:0] ped_req,
  output logic [3:0] red,
  output logic [3:0] amber,
  output logic [3:0] green,
  output logic [3:0] ped_green,
  output logic [3:0] ped_red,
  output logic [3:0] alarm,
  output logic [2:0] phase
);

  localparam int TW = $clog2(max_of(max_of(max_of(MIN_GREEN, MAX_GREEN),
                                           max_of(AMBER_T, ALLRED_T)),
                                    max_of(WALK_T, STARVE_T)) + 1);

  // Last timer value of each interval; leaving happens when the timer has
  // reached it, so an interval of N cycles spans timer values 0..N-1.
  localparam logic [TW-1:0] MG_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] XG_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] AM_LAST = TW'(AMBER_T - 1);
  localparam logic [TW-1:0] AR_LAST = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] WK_LAST = TW'(WALK_T - 1);

  state_e        r_state, w_next_state;
  logic [1:0]    r_cur, w_next_cur;     // approach owning GREEN/AMBER
  logic [1:0]    r_rr_ptr, w_arb_idx;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_veh_pend, r_ped_pend;
  logic [3:0]    w_arb_grant, w_cur_oh, w_next_oh;
  logic [3:0]    w_green_d, w_amber_d, w_ped_green_d;
  logic [3:0]    r_red, r_amber, r_green, r_ped_green, r_ped_red;
  logic          w_arb_valid, w_enter, w_competitor;

  rr_arbiter4 u_arb (
    .i_req   (r_veh_pend),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    w_arb_idx = '0;
    for (int k = 0; k < NUM_APPROACH; k++)
      if (w_arb_grant[k]) w_arb_idx = 2'(k);
  end

  assign w_cur_oh     = 4'b0001 << r_cur;
  assign w_next_oh    = 4'b0001 << w_next_cur;
  assign w_competitor = (|(r_veh_pend & ~w_cur_oh)) || (|r_ped_pend);
  assign w_enter      = (w_next_state != r_state);

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    w_next_cur   = r_cur;
    unique case (r_state)
      ALL_RED: begin
        if (r_timer >= AR_LAST) begin
          if (|r_ped_pend) begin
            w_next_state = PED_WALK;
          end else if (w_arb_valid) begin
            w_next_state = GREEN;
            w_next_cur   = w_arb_idx;
          end
        end
      end
      GREEN: begin
        // Own sensor extends green only until MAX_GREEN when someone waits.
        if (r_timer >= MG_LAST && w_competitor &&
            (!veh_req[r_cur] || r_timer >= XG_LAST))
          w_next_state = AMBER;
      end
      AMBER:    if (r_timer >= AM_LAST) w_next_state = ALL_RED;
      PED_WALK: if (r_timer >= WK_LAST) w_next_state = ALL_RED;
      default:  w_next_state = ALL_RED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ALL_RED;
      r_cur   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cur   <= w_next_cur;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timer    <= '0;
      r_rr_ptr   <= '0;
      r_veh_pend <= '0;
      r_ped_pend <= '0;
    end else begin
      if (w_enter)               r_timer <= '0;
      else if (r_timer != '1)    r_timer <= r_timer + 1'b1;

      if (r_state == AMBER && w_next_state == ALL_RED)
        r_rr_ptr <= r_cur + 2'd1;

      // The serving approach neither keeps nor re-arms its own request.
      r_veh_pend <= (r_veh_pend | veh_req)
                    & ~((r_state == GREEN) ? w_cur_oh : 4'h0)
                    & ~((w_enter && w_next_state == GREEN) ? w_next_oh : 4'h0);

      if (r_state == PED_WALK || w_next_state == PED_WALK)
        r_ped_pend <= '0;
      else
        r_ped_pend <= r_ped_pend | ped_req;
    end
  end

  // Lamp decode from the next state, registered.
  assign w_green_d     = (w_next_state == GREEN)    ? w_next_oh : 4'h0;
  assign w_amber_d     = (w_next_state == AMBER)    ? w_next_oh : 4'h0;
  assign w_ped_green_d = (w_next_state == PED_WALK) ? 4'hF      : 4'h0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_red       <= 4'hF;
      r_amber     <= '0;
      r_green     <= '0;
      r_ped_green <= '0;
      r_ped_red   <= 4'hF;
    end else begin
      r_red       <= ~(w_green_d | w_amber_d);
      r_amber     <= w_amber_d;
      r_green     <= w_green_d;
      r_ped_green <= w_ped_green_d;
      r_ped_red   <= ~w_ped_green_d;
    end
  end

  assign red       = r_red;
  assign amber     = r_amber;
  assign green     = r_green;
  assign ped_green = r_ped_green;
  assign ped_red   = r_ped_red;
  assign phase     = r_state;

`ifdef TRAFFIC_STARVE_ALARM_EN
  localparam logic [TW-1:0] ST_LAST = TW'(STARVE_T - 1);

  logic [TW-1:0] r_wait [NUM_APPROACH];
  logic [3:0]    r_alarm;
  logic [3:0]    w_green_entry;

  assign w_green_entry = (w_enter && w_next_state == GREEN) ? w_next_oh : 4'h0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_alarm <= '0;
      for (int i = 0; i < NUM_APPROACH; i++) r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_APPROACH; i++) begin
        if (w_green_entry[i]) begin
          r_wait[i]  <= '0;
          r_alarm[i] <= 1'b0;
        end else if (r_veh_pend[i]) begin
          if (r_wait[i] != '1)     r_wait[i]  <= r_wait[i] + 1'b1;
          // Alarm rises on the edge that brings the count to STARVE_T.
          if (r_wait[i] == ST_LAST) r_alarm[i] <= 1'b1;
        end
      end
    end
  end

  assign alarm = r_alarm;
`else
  assign alarm = 4'h0;
`endif

endmodule
